pio_led_fader: RTL

Downstream consumer of the 8-bit Avalon output PIO port: takes the PIO's `out_port` pattern and drives eight board LEDs through per-channel PWM. Each LED fades linearly toward on or off whenever its commanded bit changes, instead of switching hard. Sits between the PIO and the top-level LED pins; it has no bus interface and needs no software support.

---
 rtl/pio_led_fader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pio_led_fader.sv
// ---------------------------------------------------------------------------
// pio_led_fader
//
// Takes the 8-bit pattern from the Avalon output PIO and drives eight board
// LEDs through per-channel PWM. When a channel's commanded bit changes, its
// duty ramps linearly toward full on or full off. The duty only moves at the
// end of a PWM period, so a period is never cut short.
//
// Parameters
//   PWM_DIV    clocks per PWM counter step (1..65535)
//   FADE_STEP  duty change per PWM period while fading (1..255)
//
// Ports
//   clk      in   1  system clock
//   reset_n  in   1  asynchronous active-low reset
//   in_port  in   8  commanded LED pattern from the PIO (bit i = 1 -> LED i on)
//   led      out  8  registered PWM drive, active high
//   busy     out  1  registered; high while any duty differs from its target
//
// Build option
//   PIO_LED_FADE_EN  defined: duty ramps by FADE_STEP on every period wrap.
//                    undefined: duty jumps straight to 0 or 255 on the next
//                    wrap (no fade).
// ---------------------------------------------------------------------------
module pio_led_fader #(
    parameter int PWM_DIV   = 1000,
    parameter int FADE_STEP = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_port,
    output logic [7:0] led,
    output logic       busy
);

    localparam logic [15:0] DIV_TC  = 16'(PWM_DIV - 1);
    // pcnt runs 0..254 so that duty 255 compares greater than every count.
    localparam logic [7:0]  PCNT_TC = 8'd254;

    if (PWM_DIV < 1 || PWM_DIV > 65535) begin : g_bad_pwm_div
        $error("pio_led_fader: PWM_DIV must be within 1..65535");
    end

    if (FADE_STEP < 1 || FADE_STEP > 255) begin : g_bad_fade_step
        $error("pio_led_fader: FADE_STEP must be within 1..255");
    end

    logic [7:0]      tgt_q;
    logic [15:0]     presc_q, presc_d;
    logic [7:0]      pcnt_q, pcnt_d;
    logic [7:0][7:0] duty_q, duty_d;
    logic [7:0]      led_q, led_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic            wrap;

    assign tick = (presc_q == DIV_TC);
    assign wrap = tick && (pcnt_q == PCNT_TC);

    // Prescaler and PWM period counter.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        if (tick) begin
            presc_d = '0;
            if (pcnt_q == PCNT_TC) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Duty update. tgt_q is the value registered before this edge, so a
    // target change landing on the wrap clock is picked up one wrap later.
`ifdef PIO_LED_FADE_EN
    localparam logic [8:0] STEP9 = 9'(FADE_STEP);

    always_comb begin
        logic [8:0] sum;
        logic [8:0] diff;
        duty_d = duty_q;
        sum    = '0;
        diff   = '0;
        if (wrap) begin
            for (int i = 0; i < 8; i++) begin
                sum  = {1'b0, duty_q[i]} + STEP9;
                diff = {1'b0, duty_q[i]} - STEP9;
                if (tgt_q[i]) begin
                    // Carry out of bit 7 means the sum passed 255.
                    duty_d[i] = sum[8] ? 8'hFF : sum[7:0];
                end else begin
                    // Borrow into bit 8 means the step exceeded the duty.
                    duty_d[i] = diff[8] ? 8'h00 : diff[7:0];
                end
            end
        end
    end
`else
    always_comb begin
        duty_d = duty_q;
        if (wrap) begin
            for (int i = 0; i < 8; i++) begin
                duty_d[i] = tgt_q[i] ? 8'hFF : 8'h00;
            end
        end
    end
`endif

    // LED compare and busy flag, both registered.
    always_comb begin
        led_d  = '0;
        busy_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            led_d[i] = (duty_q[i] > pcnt_q);
            if (duty_q[i] != (tgt_q[i] ? 8'hFF : 8'h00)) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tgt_q   <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            duty_q  <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            tgt_q   <= in_port;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule
